hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request strobe; sampled on the clk rising edge.
REQ-004 alu_control  input  5  operation code, same encoding as ALU: 01010 mult, 01011 multu, 01100 div, 01101 divu, 01111 mtlo, 10000 mthi.
REQ-005 A  input  32  multiplicand / dividend (rs).
REQ-006 B  input  32  multiplier / divisor / mtlo-mthi source (rt).
REQ-007 busy  output  1  high while an iterative operation is in flight; the CPU stalls on it.
REQ-008 done  output  1  one-cycle pulse when HI/LO receive a mult/div result.
REQ-009 HI_output  output  32  architectural HI register.
REQ-010 LO_output  output  32  architectural LO register.

Function
REQ-011 FSM states SHALL be IDLE, RUN, FIX; busy SHALL equal (state != IDLE).
REQ-012 In IDLE, start with mult/multu/div/divu at edge N SHALL latch operands and op, zero a 6-bit counter, and go to RUN.
REQ-013 RUN SHALL perform one shift-add (mult) or restoring shift-subtract (div) iteration per edge on unsigned magnitudes, for edges N+1..N+32; at N+32 go to FIX.
REQ-014 Signed ops SHALL use |A|, |B| in RUN; FIX SHALL negate the product if operand signs differ, negate the quotient if signs differ, and give the remainder the sign of A.
REQ-015 At edge N+33 FIX SHALL write HI/LO (mult: HI=product[63:32], LO=product[31:0]; div: LO=quotient, HI=remainder), return to IDLE, and assert done for exactly the following cycle.
REQ-016 Total latency: HI/LO valid and done high after edge N+33; busy high from after edge N through edge N+33.
REQ-017 mtlo/mthi with start in IDLE SHALL write B to LO/HI at that edge; busy and done stay low; the other register is unchanged.
REQ-018 start while busy SHALL be ignored; HI/LO SHALL not change until FIX completes.
REQ-019 start with any other alu_control value SHALL be ignored.
REQ-020 Operands SHALL be captured at edge N; changes to A/B/alu_control during RUN SHALL have no effect.
REQ-021 Divide by zero (div or divu) SHALL give LO=FFFFFFFF, HI=A, with no sign fix-up.
REQ-022 div of 80000000 by FFFFFFFF SHALL give LO=80000000, HI=00000000.
REQ-023 Quotients SHALL truncate toward zero.
REQ-024 HI/LO SHALL hold their value in every cycle with no write.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, counter=0, busy=0, done=0, HI_output=0, LO_output=0.
REQ-026 Reset during RUN or FIX SHALL discard the operation; the first edge after release is treated as IDLE.

Structure
REQ-027 The package muldiv_pkg SHALL hold the alu_control opcode constants (shared with ALU) and the state enum typedef.
REQ-028 The design SHALL be a single module with no sub-module; a 64-bit accumulator/remainder register and a 32-bit shift register SHALL form the datapath.

Verification
REQ-029 mult: A=86E1FB43, B=6B72C901, start -> done after 34 cycles; HI=CD2A258D, LO=D9FF9643.
REQ-030 multu: same operands -> HI=389CEE8E, LO=D9FF9643; div: A=8396A10C, B=02A13C92 -> LO=FFFFFFD1, HI=FF30BFDA.
REQ-031 divu: A=8396A10C, B=02A13C92 -> LO=00000032, HI=0018CC88; divu by 0 with A=12345678 -> LO=FFFFFFFF, HI=12345678.
REQ-032 mtlo: B=7B93A612 -> LO=7B93A612 next cycle, busy never high; then mthi: B=0000ABCD -> HI=0000ABCD, LO unchanged.
REQ-033 start div while busy with a mult in flight -> ignored; done pulses once; HI/LO hold the mult result.
REQ-034 rst_n low at RUN cycle 10 -> busy=0, HI=LO=0 immediately; no done pulse after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit.
//   - alu_control opcode constants (same encoding the ALU decodes)
//   - FSM state enum for hilo_muldiv
package muldiv_pkg;

   localparam logic [4:0] OP_MULT  = 5'b01010;
   localparam logic [4:0] OP_MULTU = 5'b01011;
   localparam logic [4:0] OP_DIV   = 5'b01100;
   localparam logic [4:0] OP_DIVU  = 5'b01101;
   localparam logic [4:0] OP_MTLO  = 5'b01111;
   localparam logic [4:0] OP_MTHI  = 5'b10000;

   // Number of RUN iterations: one per result bit.
   localparam logic [5:0] LAST_ITER = 6'd31;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Iterative 32x32 multiply / 32/32 divide unit owning the architectural
// HI and LO registers. Multiplies use shift-add, divides use restoring
// shift-subtract, both on unsigned magnitudes over 32 RUN cycles; a FIX
// cycle applies sign correction and writes HI/LO.
//
// Handshake: start is sampled on a rising edge only while the unit is idle
// (busy low). A mult/div start raises busy from the next cycle until the
// result is written; done then pulses for exactly one cycle with HI/LO
// already valid. mtlo/mthi complete in the accepting edge without busy or
// done. Any start seen while busy, or with an unknown opcode, is dropped.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request strobe
//   alu_control[4:0]   operation code (see muldiv_pkg)
//   A[31:0], B[31:0]   rs / rt operands
//   busy               iterative operation in flight
//   done               one-cycle pulse when HI/LO take a mult/div result
//   HI_output, LO_output  architectural HI / LO
//   o_dbg_state[1:0]   current FSM state (state_t encoding)
module hilo_muldiv
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  alu_control,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI_output,
   output logic [31:0] LO_output,
   output logic [1:0]  o_dbg_state
);

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [63:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [31:0] r_opnd;     // |multiplicand| or |divisor|
   logic        r_is_div;
   logic        r_neg_q;    // operand signs differ on a signed op
   logic        r_neg_r;    // signed divide with negative dividend
   logic        r_dz;       // divide by zero: quotient left unsigned
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_is_md;
   logic        w_is_div;
   logic        w_signed;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_add;
   logic [63:0] w_mul_next;
   logic [33:0] w_sub;
   logic [63:0] w_div_next;
   logic [63:0] w_prod;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   assign w_is_div = (alu_control == OP_DIV) || (alu_control == OP_DIVU);
   assign w_is_md  = w_is_div || (alu_control == OP_MULT) || (alu_control == OP_MULTU);
   assign w_signed = (alu_control == OP_MULT) || (alu_control == OP_DIV);
   assign w_abs_a  = (w_signed && A[31]) ? -A : A;
   assign w_abs_b  = (w_signed && B[31]) ? -B : B;

   // Shift-add: conditionally add multiplicand to the upper half, then shift
   // the 33-bit sum and the remaining multiplier bits right together.
   assign w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
   assign w_mul_next = {w_add, r_acc[31:1]};

   // Restoring divide: the shifted partial remainder needs 33 bits; a borrow
   // in bit 33 means the trial subtraction is discarded.
   assign w_sub      = {1'b0, r_acc[63:31]} - {2'b00, r_opnd};
   assign w_div_next = w_sub[33] ? {r_acc[62:0], 1'b0}
                                 : {w_sub[31:0], r_acc[30:0], 1'b1};

   // With divisor zero the remainder path still yields |A|, and restoring
   // the sign of A gives back A itself.
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quot = (r_neg_q && !r_dz) ? -r_acc[31:0] : r_acc[31:0];
   assign w_rem  = r_neg_r ? -r_acc[63:32] : r_acc[63:32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 6'd0;
         r_acc    <= 64'd0;
         r_opnd   <= 32'd0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_is_md) begin
                     r_state  <= S_RUN;
                     r_cnt    <= 6'd0;
                     r_is_div <= w_is_div;
                     r_acc    <= {32'd0, (w_is_div ? w_abs_a : w_abs_b)};
                     r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                     r_neg_q  <= w_signed && (A[31] ^ B[31]);
                     r_neg_r  <= w_signed && A[31];
                     r_dz     <= (B == 32'd0);
                  end else if (alu_control == OP_MTLO) begin
                     r_lo <= B;
                  end else if (alu_control == OP_MTHI) begin
                     r_hi <= B;
                  end
               end
            end
            S_RUN: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == LAST_ITER) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = r_done;
   assign HI_output   = r_hi;
   assign LO_output   = r_lo;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  alu_control;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] HI_output;
   logic [31:0] LO_output;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mh = 32'd0;   // model HI
   logic [31:0] ml = 32'd0;   // model LO
   logic [63:0] exp_q[$];

   hilo_muldiv dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .alu_control (alu_control),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .HI_output   (HI_output),
      .LO_output   (LO_output),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Returns {HI, LO} computed with plain integer arithmetic.
   function automatic logic [63:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         OP_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic idle_inputs();
      start       = 1'b0;
      alu_control = 5'd0;
      A           = 32'd0;
      B           = 32'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mh = 32'd0;
      ml = 32'd0;
      exp_q.delete();
      @(negedge clk);
   endtask

   // Issue a mult/div and follow it to done. With disturb set, the inputs
   // (including start) are scrambled every cycle while the op is in flight.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
      int          k;
      bit          seen;
      logic [63:0] e;
      start = 1'b1; alu_control = op; A = a; B = b;
      exp_q.push_back(ref_op(op, a, b));
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
      k = 0;
      seen = 1'b0;
      while (k < 40 && !seen) begin
         if (disturb) begin
            start       = 1'($urandom_range(0, 1));
            alu_control = 5'($urandom_range(0, 31));
            A           = $urandom;
            B           = $urandom;
         end
         @(negedge clk);
         k++;
         if (k == 16) chk({tag, "_hold_mid"}, {HI_output, LO_output}, {mh, ml});
         if (done) seen = 1'b1;
      end
      idle_inputs();
      chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
      chk({tag, "_latency"}, 64'(k), 64'd33);
      chk({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
      e = exp_q.pop_front();
      chk({tag, "_hilo"}, {HI_output, LO_output}, e);
      {mh, ml} = e;
      @(negedge clk);
      chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
      chk({tag, "_hilo_hold"}, {HI_output, LO_output}, {mh, ml});
   endtask

   // Single-cycle requests: mtlo/mthi or an unrecognised opcode.
   task automatic quick_op(input string tag, input logic [4:0] op, input logic [31:0] b);
      start = 1'b1; alu_control = op; A = $urandom; B = b;
      if (op == OP_MTLO) ml = b;
      else if (op == OP_MTHI) mh = b;
      @(negedge clk);
      idle_inputs();
      chk({tag, "_busy"}, {62'd0, busy, done}, 64'd0);
      chk({tag, "_hilo"}, {HI_output, LO_output}, {mh, ml});
      @(negedge clk);
      chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t dvec[7];

   initial begin
      logic [4:0]  op;
      logic [31:0] a, b;
      int          dcount;
      int          sel;

      dvec[0] = '{OP_MULT,  32'h86E1FB43, 32'h6B72C901, 32'hCD2A258D, 32'hD9FF9643};
      dvec[1] = '{OP_MULTU, 32'h86E1FB43, 32'h6B72C901, 32'h389CEE8E, 32'hD9FF9643};
      dvec[2] = '{OP_DIV,   32'h8396A10C, 32'h02A13C92, 32'hFF30BFDA, 32'hFFFFFFD1};
      dvec[3] = '{OP_DIVU,  32'h8396A10C, 32'h02A13C92, 32'h0018CC88, 32'h00000032};
      dvec[4] = '{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
      dvec[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      dvec[6] = '{OP_DIV,   32'h87654321, 32'h00000000, 32'h87654321, 32'hFFFFFFFF};

      rst_n = 1'b0;
      idle_inputs();
      #1;
      chk("reset_async", {30'd0, busy, done, HI_output, LO_output}, 64'd0);
      do_reset();
      chk("reset_state", {30'd0, busy, done, HI_output, LO_output}, 64'd0);

      foreach (dvec[i]) begin
         run_op($sformatf("dir%0d", i), dvec[i].op, dvec[i].a, dvec[i].b, 1'b0);
         chk($sformatf("dir%0d_const", i), {HI_output, LO_output}, {dvec[i].hi, dvec[i].lo});
      end

      // mtlo then mthi: the other register keeps its value.
      quick_op("mtlo", OP_MTLO, 32'h7B93A612);
      chk("mtlo_val", {32'd0, LO_output}, 64'h7B93A612);
      quick_op("mthi", OP_MTHI, 32'h0000ABCD);
      chk("mthi_val", {HI_output, LO_output}, {32'h0000ABCD, 32'h7B93A612});

      // A div request while a mult is in flight must be dropped.
      start = 1'b1; alu_control = OP_MULT; A = 32'h00001234; B = 32'hFFFF0003;
      exp_q.push_back(ref_op(OP_MULT, 32'h00001234, 32'hFFFF0003));
      @(negedge clk);
      alu_control = OP_DIV; A = 32'h00000064; B = 32'h00000007;
      dcount = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (c == 0) start = 1'b0;
         if (done) dcount++;
      end
      idle_inputs();
      chk("busy_ignore_done_cnt", 64'(dcount), 64'd1);
      {mh, ml} = exp_q.pop_front();
      chk("busy_ignore_hilo", {HI_output, LO_output}, {mh, ml});

      // Unrecognised opcodes.
      foreach (dvec[i]) begin
         do op = 5'($urandom_range(0, 31));
         while (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTLO, OP_MTHI});
         quick_op($sformatf("badop%0d", i), op, $urandom);
      end

      // Randomised traffic with corner-biased operands.
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'h80000000;
            1: b = 32'hFFFFFFFF;
            2: b = 32'd0;
            3: b = 32'($urandom_range(1, 40));
            default: ;
         endcase
         case (sel)
            0: quick_op($sformatf("rnd%0d_mtlo", i), OP_MTLO, b);
            1: quick_op($sformatf("rnd%0d_mthi", i), OP_MTHI, b);
            2, 3: run_op($sformatf("rnd%0d_mult", i), OP_MULT, a, b, 1'($urandom_range(0, 1)));
            4, 5: run_op($sformatf("rnd%0d_multu", i), OP_MULTU, a, b, 1'($urandom_range(0, 1)));
            6, 7: run_op($sformatf("rnd%0d_div", i), OP_DIV, a, b, 1'($urandom_range(0, 1)));
            default: run_op($sformatf("rnd%0d_divu", i), OP_DIVU, a, b, 1'($urandom_range(0, 1)));
         endcase
      end

      // Reset in the middle of RUN discards the operation.
      start = 1'b1; alu_control = OP_MULTU; A = $urandom; B = $urandom;
      @(negedge clk);
      idle_inputs();
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset", {30'd0, busy, done, HI_output, LO_output}, 64'd0);
      mh = 32'd0;
      ml = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) dcount++;
      end
      chk("midrun_no_done", 64'(dcount), 64'd0);
      chk("midrun_hilo", {HI_output, LO_output}, 64'd0);

      // Unit is fully usable after the aborted operation.
      run_op("post_reset", OP_DIV, 32'hFFFFFF9C, 32'h00000007, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
